player_move_grid: RTL

- Parametrised successor to the single-sprite mover: per-frame, grid-aware movement controller for one Bomberman player sprite.
- Decodes the keypad direction and scales step by a runtime speed level.
- Applies corner-assist alignment to the tile grid, rolls back the last step on collision, and clamps to the play-field.
- Output feeds the sprite drawer and collision matrix.

---
 rtl/player_move_grid.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/player_move_grid.sv
`default_nettype none
// ============================================================================
// Module   : player_move_grid
// Purpose  : Per-frame, grid-aware movement controller for one player sprite
//            (keypad decode, speed scaling, corner assist, rollback, clamping).
// Revision : 1.0  initial release
// ============================================================================
module player_move_grid #(
    parameter int INITIAL_X    = 288,
    parameter int INITIAL_Y    = 188,
    parameter int SPEED        = 64,
    parameter int FP_SHIFT     = 6,
    parameter int TILE         = 32,
    parameter int GRID_X0      = 32,
    parameter int GRID_Y0      = 92,
    parameter int ALIGN_TOL    = 8,
    parameter int FRAME_LEFT   = 2,
    parameter int FRAME_RIGHT  = 576,
    parameter int FRAME_TOP    = 92,
    parameter int FRAME_BOTTOM = 416
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [3:0]         key,
    input  logic               keyIsPressed,
    input  logic [1:0]         speedLevel,
    input  logic               freeze,
    input  logic               collision,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               moving,
    output logic [1:0]         direction
);

    localparam logic [3:0] KEY_UP    = 4'd8;
    localparam logic [3:0] KEY_DOWN  = 4'd2;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_RIGHT = 4'd6;

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic signed [31:0] TILE_FP   = TILE << FP_SHIFT;
    localparam logic signed [31:0] OFF_MASK  = TILE_FP - 32'sd1;
    localparam logic signed [31:0] TOL_FP    = ALIGN_TOL << FP_SHIFT;
    localparam logic signed [31:0] HI_FP     = (TILE - ALIGN_TOL) << FP_SHIFT;
    localparam logic signed [31:0] GX0_FP    = GRID_X0 << FP_SHIFT;
    localparam logic signed [31:0] GY0_FP    = GRID_Y0 << FP_SHIFT;
    localparam logic signed [31:0] INIT_X_FP = INITIAL_X << FP_SHIFT;
    localparam logic signed [31:0] INIT_Y_FP = INITIAL_Y << FP_SHIFT;
    localparam logic signed [31:0] LEFT_FP   = FRAME_LEFT << FP_SHIFT;
    localparam logic signed [31:0] RIGHT_FP  = FRAME_RIGHT << FP_SHIFT;
    localparam logic signed [31:0] TOP_FP    = FRAME_TOP << FP_SHIFT;
    localparam logic signed [31:0] BOTTOM_FP = FRAME_BOTTOM << FP_SHIFT;
    localparam logic signed [31:0] SPEED_S   = SPEED;

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        MOVE            = 3'd1,
        WAIT_FOR_EOF    = 3'd2,
        POSITION_CHANGE = 3'd3,
        POSITION_LIMITS = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [31:0] pos_x;
    logic signed [31:0] pos_y;
    logic signed [31:0] saved_x;
    logic signed [31:0] saved_y;
    logic signed [31:0] vel_x;
    logic signed [31:0] vel_y;

    logic signed [31:0] off_x;
    logic signed [31:0] off_y;
    logic signed [31:0] step;
    logic signed [31:0] vel_x_nxt;
    logic signed [31:0] vel_y_nxt;
    logic               req_horiz;
    logic               req_vert;
    logic               req_valid;
    logic [1:0]         req_dir;

    function automatic logic signed [31:0] smin(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a < b) ? a : b;
    endfunction

    // Nudge toward the nearest grid line when within tolerance of it.
    function automatic logic signed [31:0] assist(input logic signed [31:0] off,
                                                  input logic signed [31:0] stp);
        if (off <= TOL_FP) begin
            return -smin(stp, off);
        end else if (off >= HI_FP) begin
            return smin(stp, TILE_FP - off);
        end else begin
            return '0;
        end
    endfunction

    function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

    assign topLeftX = 11'(pos_x >>> FP_SHIFT);
    assign topLeftY = 11'(pos_y >>> FP_SHIFT);

    // Offsets within the tile; the mask yields a non-negative modulo.
    assign off_x = (pos_x - GX0_FP) & OFF_MASK;
    assign off_y = (pos_y - GY0_FP) & OFF_MASK;

    always_comb begin
        req_horiz = (key == KEY_LEFT) || (key == KEY_RIGHT);
        req_vert  = (key == KEY_UP)   || (key == KEY_DOWN);
        req_valid = keyIsPressed && !freeze && (req_horiz || req_vert);
        step      = SPEED_S * $signed({30'd0, speedLevel} + 32'd1);
        vel_x_nxt = '0;
        vel_y_nxt = '0;
        req_dir   = DIR_DOWN;

        case (key)
            KEY_UP:    req_dir = DIR_UP;
            KEY_LEFT:  req_dir = DIR_LEFT;
            KEY_RIGHT: req_dir = DIR_RIGHT;
            default:   req_dir = DIR_DOWN;
        endcase

        if (req_valid) begin
            if (req_horiz) begin
                if (off_y == '0) begin
                    vel_x_nxt = (key == KEY_RIGHT) ? step : -step;
                end else begin
                    vel_y_nxt = assist(off_y, step);
                end
            end else begin
                if (off_x == '0) begin
                    vel_y_nxt = (key == KEY_DOWN) ? step : -step;
                end else begin
                    vel_x_nxt = assist(off_x, step);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Collision has priority over the frame pulse while in MOVE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (startOfFrame) state_nxt = MOVE;
            end
            MOVE: begin
                if (collision) begin
                    state_nxt = WAIT_FOR_EOF;
                end else if (startOfFrame) begin
                    state_nxt = POSITION_CHANGE;
                end
            end
            WAIT_FOR_EOF: begin
                if (startOfFrame) state_nxt = POSITION_CHANGE;
            end
            POSITION_CHANGE: state_nxt = POSITION_LIMITS;
            POSITION_LIMITS: state_nxt = MOVE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pos_x     <= '0;
            pos_y     <= '0;
            saved_x   <= '0;
            saved_y   <= '0;
            vel_x     <= '0;
            vel_y     <= '0;
            moving    <= 1'b0;
            direction <= DIR_DOWN;
        end else begin
            case (state)
                IDLE: begin
                    pos_x <= INIT_X_FP;
                    pos_y <= INIT_Y_FP;
                    vel_x <= '0;
                    vel_y <= '0;
                end
                MOVE: begin
                    if (req_valid) direction <= req_dir;
                    if (collision) begin
                        pos_x <= saved_x;
                        pos_y <= saved_y;
                        vel_x <= '0;
                        vel_y <= '0;
                    end else begin
                        vel_x <= vel_x_nxt;
                        vel_y <= vel_y_nxt;
                    end
                end
                WAIT_FOR_EOF: begin
                    vel_x <= '0;
                    vel_y <= '0;
                end
                POSITION_CHANGE: begin
                    saved_x <= pos_x;
                    saved_y <= pos_y;
                    pos_x   <= pos_x + vel_x;
                    pos_y   <= pos_y + vel_y;
                    moving  <= (vel_x != '0) || (vel_y != '0);
                end
                POSITION_LIMITS: begin
                    pos_x <= clamp(pos_x, LEFT_FP, RIGHT_FP);
                    pos_y <= clamp(pos_y, TOP_FP, BOTTOM_FP);
                end
                default: begin
                    vel_x <= '0;
                    vel_y <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
